// File: rtl/bram_instr_fetch_pkg.sv
// Package: cicero_fetch_pkg
// Shared types and elaboration-time helpers for the instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   log2_f        : ceil(log2) for constant parameter derivation
//   slots_f       : instructions per BRAM line
//   pc_width_f    : instruction-index width = line address bits + slot bits
package cicero_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fetch_state_t;

  function automatic int log2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int slots_f(input int line_width, input int instr_width);
    return line_width / instr_width;
  endfunction

  function automatic int pc_width_f(input int line_addr_width, input int line_width,
                                    input int instr_width);
    return line_addr_width + log2_f(slots_f(line_width, instr_width));
  endfunction

endpackage

// File: rtl/bram_instr_fetch_if.sv
// Interface: bram_instr_fetch_if
// Core-side request/response channel of the fetch stage (valid/ready both ways).
//   req_valid/req_ready/req_pc        : fetch request, core -> fetch unit
//   rsp_valid/rsp_ready/rsp_instr/pc  : fetched instruction, fetch unit -> core
// Modports: master = engine core, slave = fetch unit.
interface bram_instr_fetch_if
  import cicero_fetch_pkg::*;
#(
  parameter int PC_WIDTH    = pc_width_f(9, 64, 16),
  parameter int INSTR_WIDTH = 16
);

  logic                   req_valid;
  logic                   req_ready;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [INSTR_WIDTH-1:0] rsp_instr;
  logic [PC_WIDTH-1:0]    rsp_pc;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_pc
  );

endinterface

// File: rtl/bram_instr_fetch_line_slot_mux.sv
// Module: line_slot_mux
// Combinational instruction select from one BRAM line. Slot 0 is the LSB word.
//   line_data : LINE_WIDTH-bit line
//   slot      : instruction slot within the line
//   instr     : selected INSTR_WIDTH-bit instruction
module line_slot_mux
  import cicero_fetch_pkg::*;
#(
  parameter  int LINE_WIDTH  = 64,
  parameter  int INSTR_WIDTH = 16,
  localparam int SLOTS       = slots_f(LINE_WIDTH, INSTR_WIDTH),
  localparam int SLOT_BITS   = log2_f(SLOTS)
) (
  input  logic [LINE_WIDTH-1:0]  line_data,
  input  logic [SLOT_BITS-1:0]   slot,
  output logic [INSTR_WIDTH-1:0] instr
);

  logic [INSTR_WIDTH-1:0] words [SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_split
    assign words[g] = line_data[g*INSTR_WIDTH +: INSTR_WIDTH];
  end

  assign instr = words[slot];

endmodule

// File: rtl/bram_instr_fetch.sv
// Module: bram_instr_fetch
// Instruction fetch stage behind the asymmetric code BRAM. Reads whole lines,
// keeps the last line in a one-entry buffer and returns the addressed
// instruction to the core. Hits answer 1 cycle after accept, misses 3 cycles.
//   clk, rst      : clock; asynchronous active-low reset
//   core          : request/response channel (slave side)
//   invalidate    : drop the buffered line (program reload)
//   mem_r_valid   : BRAM read enable (high only in ISSUE)
//   mem_r_addr    : BRAM line address
//   mem_r_data    : BRAM read data, valid one cycle after the read
module bram_instr_fetch
  import cicero_fetch_pkg::*;
#(
  parameter  int LINE_WIDTH      = 64,
  parameter  int LINE_ADDR_WIDTH = 9,
  parameter  int INSTR_WIDTH     = 16,
  localparam int SLOTS           = slots_f(LINE_WIDTH, INSTR_WIDTH),
  localparam int SLOT_BITS       = log2_f(SLOTS),
  localparam int PC_WIDTH        = LINE_ADDR_WIDTH + SLOT_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  bram_instr_fetch_if.slave          core,
  input  logic                       invalidate,
  output logic                       mem_r_valid,
  output logic [LINE_ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [LINE_WIDTH-1:0]      mem_r_data
);

  fetch_state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [LINE_WIDTH-1:0]      line_q, line_d;
  logic [LINE_ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                       line_valid_q, line_valid_d;
  logic                       inv_pending_q, inv_pending_d;
  logic [INSTR_WIDTH-1:0]     rsp_instr_q, rsp_instr_d;

  logic [LINE_ADDR_WIDTH-1:0] req_line;
  logic [SLOT_BITS-1:0]       req_slot;
  logic                       hit;
  logic                       req_ready;
  logic                       accept;
  logic [LINE_WIDTH-1:0]      mux_line;
  logic [SLOT_BITS-1:0]       mux_slot;
  logic [INSTR_WIDTH-1:0]     mux_instr;

  assign req_line = core.req_pc[PC_WIDTH-1:SLOT_BITS];
  assign req_slot = core.req_pc[SLOT_BITS-1:0];
  assign hit      = line_valid_q && (tag_q == req_line);

  // Gating IDLE's ready with rst keeps req_ready low while reset is held.
  assign req_ready = ((state_q == IDLE) && rst) || ((state_q == RESP) && core.rsp_ready);
  assign accept    = core.req_valid && req_ready;

  // WAIT selects from the arriving BRAM line at the latched slot; otherwise
  // the buffered line is indexed by the incoming request for a hit.
  assign mux_line = (state_q == WAIT) ? mem_r_data : line_q;
  assign mux_slot = (state_q == WAIT) ? pc_q[SLOT_BITS-1:0] : req_slot;

  line_slot_mux #(
    .LINE_WIDTH  (LINE_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_line_slot_mux (
    .line_data (mux_line),
    .slot      (mux_slot),
    .instr     (mux_instr)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    line_d        = line_q;
    tag_d         = tag_q;
    line_valid_d  = line_valid_q;
    inv_pending_d = inv_pending_q;
    rsp_instr_d   = rsp_instr_q;

    unique case (state_q)
      IDLE, RESP: begin
        // In RESP an accept is only possible while rsp_ready is high, so a
        // new request and the response handshake share the same edge.
        if (accept) begin
          pc_d = core.req_pc;
          if (hit) begin
            rsp_instr_d = mux_instr;
            state_d     = RESP;
          end else begin
            state_d     = ISSUE;
          end
        end else if ((state_q == RESP) && core.rsp_ready) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // An invalidate seen now must survive the WAIT fill below.
        inv_pending_d = invalidate;
        state_d       = WAIT;
      end
      WAIT: begin
        line_d        = mem_r_data;
        tag_d         = pc_q[PC_WIDTH-1:SLOT_BITS];
        line_valid_d  = !inv_pending_q;
        rsp_instr_d   = mux_instr;
        inv_pending_d = 1'b0;
        state_d       = RESP;
      end
      default: state_d = IDLE;
    endcase

    // Applied last: the hit above already used the pre-invalidate line_valid.
    if (invalidate) line_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      tag_q         <= '0;
      line_valid_q  <= 1'b0;
      inv_pending_q <= 1'b0;
      rsp_instr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      tag_q         <= tag_d;
      line_valid_q  <= line_valid_d;
      inv_pending_q <= inv_pending_d;
      rsp_instr_q   <= rsp_instr_d;
    end
  end

  // NOTE: the line buffer is data storage guarded by line_valid_q, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign core.req_ready = req_ready;
  assign core.rsp_valid = (state_q == RESP);
  assign core.rsp_instr = rsp_instr_q;
  assign core.rsp_pc    = pc_q;
  assign mem_r_valid    = (state_q == ISSUE);
  assign mem_r_addr     = pc_q[PC_WIDTH-1:SLOT_BITS];

endmodule

// File: tb/tb_bram_instr_fetch.sv
// Testbench for bram_instr_fetch: directed scenarios followed by random
// fetches, checked against a line-buffer reference model.
module tb_bram_instr_fetch;
  import cicero_fetch_pkg::*;

  localparam int LW  = 64;
  localparam int LAW = 9;
  localparam int IW  = 16;
  localparam int PCW = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           invalidate;
  logic           mem_r_valid;
  logic [LAW-1:0] mem_r_addr;
  logic [LW-1:0]  mem_r_data;

  always #5 clk = ~clk;

  bram_instr_fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) core ();

  bram_instr_fetch #(
    .LINE_WIDTH      (LW),
    .LINE_ADDR_WIDTH (LAW),
    .INSTR_WIDTH     (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (core),
    .invalidate  (invalidate),
    .mem_r_valid (mem_r_valid),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data)
  );

  // BRAM model: one-cycle registered read.
  logic [LW-1:0] bram [512];
  initial mem_r_data = '0;
  always @(posedge clk) if (mem_r_valid) mem_r_data <= bram[mem_r_addr];

  int errors = 0;
  int checks = 0;

  // Reference model: is a line buffered, and which one.
  bit m_valid = 1'b0;
  int m_tag   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_instr(input int pc);
    logic [63:0] l;
    l = bram[pc / 4];
    return l[(pc % 4) * 16 +: 16];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"},   core.req_ready, 0);
    check({tag, ".rsp_valid"},   core.rsp_valid, 0);
    check({tag, ".mem_r_valid"}, mem_r_valid, 0);
    check({tag, ".rsp_instr"},   core.rsp_instr, 0);
    check({tag, ".rsp_pc"},      core.rsp_pc, 0);
    check({tag, ".mem_r_addr"},  mem_r_addr, 0);
  endtask

  // Called at a negedge. inv_at: -1 none, 0 with the request, k = k cycles
  // after accept (only meaningful while a miss is in flight).
  task automatic fetch(input int pc, input int inv_at, input int hold);
    bit             hit;
    int             lat;
    int             reads;
    logic [LAW-1:0] raddr;
    logic [PCW-1:0] pc_bits;
    hit     = m_valid && (m_tag == pc / 4);
    pc_bits = pc[PCW-1:0];
    core.req_valid = 1'b1;
    core.req_pc    = pc_bits;
    invalidate     = (inv_at == 0);
    #1;
    check("req_ready", core.req_ready, 1);
    @(negedge clk);
    core.req_valid = 1'b0;
    invalidate     = 1'b0;
    lat   = 1;
    reads = 0;
    raddr = '0;
    while (!core.rsp_valid && lat < 10) begin
      if (mem_r_valid) begin
        reads++;
        raddr = mem_r_addr;
      end
      invalidate = (inv_at == lat);
      @(negedge clk);
      lat++;
    end
    invalidate = 1'b0;
    check("rsp_valid", core.rsp_valid, 1);
    check("latency", lat, hit ? 1 : 3);
    check("mem_reads", reads, hit ? 0 : 1);
    if (!hit) check("mem_r_addr", raddr, pc / 4);
    check("mem_idle_in_resp", mem_r_valid, 0);
    check("rsp_instr", core.rsp_instr, ref_instr(pc));
    check("rsp_pc", core.rsp_pc, pc);
    if (!hit) begin
      m_tag   = pc / 4;
      m_valid = !(inv_at == 1 || inv_at == 2);
    end else if (inv_at == 0) begin
      m_valid = 1'b0;
    end
    if (hold > 0) begin
      core.rsp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("hold.rsp_valid", core.rsp_valid, 1);
        check("hold.rsp_instr", core.rsp_instr, ref_instr(pc));
        check("hold.rsp_pc", core.rsp_pc, pc);
        check("hold.req_ready", core.req_ready, 0);
        check("hold.mem_r_valid", mem_r_valid, 0);
      end
      core.rsp_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n, input bit inv);
    core.req_valid = 1'b0;
    invalidate     = inv;
    repeat (n) begin
      @(negedge clk);
      invalidate = 1'b0;
      check("idle.rsp_valid", core.rsp_valid, 0);
      check("idle.mem_r_valid", mem_r_valid, 0);
    end
    if (inv) m_valid = 1'b0;
  endtask

  int lines [5] = '{0, 1, 2, 5, 511};

  initial begin
    int r;
    int pc;
    int inv_at;
    int hold;
    core.req_valid = 1'b0;
    core.req_pc    = '0;
    core.rsp_ready = 1'b1;
    invalidate     = 1'b0;
    for (int i = 0; i < 512; i++) bram[i] = {$urandom, $urandom};
    bram[0] = 64'h4444_3333_2222_1111;
    bram[5] = 64'hDDDD_CCCC_BBBB_AAAA;

    // Reset state.
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", core.req_ready, 1);

    // Cold miss, then three back-to-back hits.
    fetch(2, -1, 0);
    fetch(0, -1, 0);
    fetch(1, -1, 0);
    fetch(3, -1, 0);
    // Miss to line 5, then refetch of line 0.
    fetch(21, -1, 0);
    fetch(1, -1, 0);
    // Back-pressure for 4 cycles in RESP.
    fetch(3, -1, 4);
    // Invalidate during WAIT: response served, next request misses.
    idle(1, 1'b1);
    fetch(2, 2, 0);
    fetch(3, -1, 0);
    // Top of the pc range.
    fetch(2047, -1, 0);
    fetch(2046, -1, 0);
    // Invalidate with a hit accept: hit uses the old line, then cleared.
    fetch(2045, 0, 0);
    fetch(2044, -1, 0);
    idle(2, 1'b0);

    // Asynchronous reset while a read is in WAIT.
    core.req_valid = 1'b1;
    core.req_pc    = 11'd4;
    @(negedge clk);
    core.req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_wait", core.rsp_valid, 0);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch(0, -1, 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      pc = lines[$urandom_range(0, 4)] * 4 + int'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      inv_at = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 2 : -1;
      hold   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      fetch(pc, inv_at, hold);
      r = $urandom_range(0, 9);
      if (r == 0) idle(int'($urandom_range(1, 2)), 1'b0);
      else if (r == 1) idle(1, 1'b1);
    end
    idle(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
